// File: rtl/frame_result_buffer_if.sv
// Host bus, pixel stream and result port of the frame/result buffer.
// The slave modport is the buffer side and the master modport is the host/accelerator side.
interface frame_result_buffer_if #(
  parameter int DATA_W = 16
);
  logic              chipselect;
  logic [3:0]        address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;

  logic              res_we;
  logic [3:0]        res_idx;
  logic [DATA_W-1:0] res_data;
  logic              res_last;

  logic              irq;

  modport slave (
    input  chipselect, address, read, write, writedata,
    input  out_ready, res_we, res_idx, res_data, res_last,
    output readdata, out_data, out_valid, out_last, irq
  );

  modport master (
    output chipselect, address, read, write, writedata,
    output out_ready, res_we, res_idx, res_data, res_last,
    input  readdata, out_data, out_valid, out_last, irq
  );
endinterface

// File: rtl/frame_result_buffer.sv
// Frame buffer between the host and the digit accelerator: fill, stream, collect results.
// Optional frame-done interrupt is built when FRAME_RESULT_BUFFER_IRQ_EN is defined.
module frame_result_buffer #(
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 25,
  parameter int NUM_RESULTS = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  frame_result_buffer_if.slave bus
);

  // state    | meaning
  // S_FILL   | host writes pixels into the buffer
  // S_STREAM | buffer presented to the accelerator
  // S_WAIT   | collecting result writes
  // S_DONE   | results final, readable until clear
  typedef enum logic [1:0] {S_FILL, S_STREAM, S_WAIT, S_DONE} state_t;

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [3:0]       NR4      = 4'(NUM_RESULTS);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [IDX_W-1:0]    idx_q, idx_d, nxt_idx;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic                ovf_q, ovf_d;
  logic [DATA_W-1:0]   readdata_q, readdata_d;
  logic [DATA_W-1:0]   rd_mux, status;
  logic [DATA_W-1:0]   pix_q [DEPTH];
  logic [DATA_W-1:0]   res_q [NUM_RESULTS];

  logic bus_wr, bus_rd, ctrl_wr, clear, data_wr, xfer;
  logic pix_we, res_wr, last_fill, last_pix, res_done;

`ifdef FRAME_RESULT_BUFFER_IRQ_EN
  logic irq_q, irq_d, irq_ack;
`endif

  assign bus_wr    = bus.chipselect & bus.write;
  assign bus_rd    = bus.chipselect & bus.read;
  assign ctrl_wr   = bus_wr & (bus.address == 4'd0);
  assign clear     = ctrl_wr & bus.writedata[0];
  assign data_wr   = bus_wr & (bus.address == 4'd1);
  assign xfer      = out_valid_q & bus.out_ready;
  assign last_fill = (count_q == LAST_CNT);
  assign last_pix  = (idx_q == LAST_IDX);
  assign nxt_idx   = idx_q + IDX_W'(1);
  assign res_done  = (state_q == S_WAIT) & bus.res_we & bus.res_last;

`ifdef FRAME_RESULT_BUFFER_IRQ_EN
  assign irq_ack   = ctrl_wr & bus.writedata[1];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FILL;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_FILL;
    end else begin
      unique case (state_q)
        S_FILL:   if (data_wr && last_fill) state_d = S_STREAM;
        S_STREAM: if (xfer && last_pix)     state_d = S_WAIT;
        S_WAIT:   if (res_done)             state_d = S_DONE;
        S_DONE:   state_d = S_DONE;
        default:  state_d = S_FILL;
      endcase
    end
  end

  always_comb begin
    count_d     = count_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    ovf_d       = ovf_q;
    pix_we      = 1'b0;
    res_wr      = 1'b0;
`ifdef FRAME_RESULT_BUFFER_IRQ_EN
    irq_d       = irq_q;
`endif
    if (clear) begin
      count_d     = '0;
      idx_d       = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      ovf_d       = 1'b0;
`ifdef FRAME_RESULT_BUFFER_IRQ_EN
      irq_d       = 1'b0;
`endif
    end else begin
      if (data_wr) begin
        if (state_q == S_FILL) begin
          pix_we  = 1'b1;
          count_d = count_q + CNT_W'(1);
          // Read ahead: word 0 is already stored, so present it on entry to STREAM.
          if (last_fill) begin
            idx_d       = '0;
            out_data_d  = pix_q[0];
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
          end
        end else begin
          ovf_d = 1'b1;
        end
      end

      if ((state_q == S_STREAM) && xfer) begin
        if (last_pix) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end else begin
          idx_d      = nxt_idx;
          out_data_d = pix_q[nxt_idx];
          out_last_d = (nxt_idx == LAST_IDX);
        end
      end

      if ((state_q == S_WAIT) && bus.res_we && (bus.res_idx < NR4))
        res_wr = 1'b1;

`ifdef FRAME_RESULT_BUFFER_IRQ_EN
      // A frame-done event in the same cycle as an acknowledge is not lost.
      if (irq_ack)  irq_d = 1'b0;
      if (res_done) irq_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q     <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      ovf_q       <= 1'b0;
      readdata_q  <= '0;
`ifdef FRAME_RESULT_BUFFER_IRQ_EN
      irq_q       <= 1'b0;
`endif
    end else begin
      count_q     <= count_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      ovf_q       <= ovf_d;
      readdata_q  <= readdata_d;
`ifdef FRAME_RESULT_BUFFER_IRQ_EN
      irq_q       <= irq_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (pix_we) pix_q[count_q[IDX_W-1:0]] <= bus.writedata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_RESULTS; i++) res_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_RESULTS; i++)
        if (res_wr && (bus.res_idx == 4'(i))) res_q[i] <= bus.res_data;
    end
  end

  always_comb begin
    status    = '0;
    status[0] = (state_q == S_DONE);
    status[1] = (state_q == S_STREAM) || (state_q == S_WAIT);
    status[2] = ovf_q;
`ifdef FRAME_RESULT_BUFFER_IRQ_EN
    status[3] = irq_q;
`endif
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      4'd0:    rd_mux = status;
      4'd2:    rd_mux = DATA_W'(count_q);
      default: begin
        for (int i = 0; i < NUM_RESULTS; i++)
          if (bus.address == 4'(i + 3)) rd_mux = res_q[i];
      end
    endcase
  end

  always_comb begin
    readdata_d = readdata_q;
    if (bus_rd) readdata_d = rd_mux;
  end

  assign bus.readdata  = readdata_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
`ifdef FRAME_RESULT_BUFFER_IRQ_EN
  assign bus.irq       = irq_q;
`else
  assign bus.irq       = 1'b0;
`endif

endmodule

// File: tb/tb_frame_result_buffer.sv
// Scoreboard bench for frame_result_buffer: random pixels, ready patterns and result writes
// checked against a queue/array model of the fill-stream-collect sequence.
module tb_frame_result_buffer;
  localparam int DW    = 16;
  localparam int DEPTH = 25;
  localparam int NR    = 10;
`ifdef FRAME_RESULT_BUFFER_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  localparam int P_FILL = 0, P_STREAM = 1, P_WAIT = 2, P_DONE = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  frame_result_buffer_if #(.DATA_W(DW)) bus ();

  frame_result_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_RESULTS(NR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model
  logic [DW-1:0] m_fill [$];
  logic [DW-1:0] m_res [NR];
  bit            m_ovf;
  bit            m_irq;
  int            m_phase;

  logic [DW:0]   exp_pix [$];   // {last, data}
  logic [DW-1:0] exp_rd  [$];

  int  rdy_mode   = 0;          // 0 manual, 1 toggle, 2 random
  bit  rdy_manual = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input logic [3:0] a);
    logic [DW-1:0] r;
    r = '0;
    if (a == 4'd0) begin
      r[0] = (m_phase == P_DONE);
      r[1] = (m_phase == P_STREAM) || (m_phase == P_WAIT);
      r[2] = m_ovf;
      r[3] = m_irq && IRQ_EN;
    end else if (a == 4'd2) begin
      r = DW'(m_fill.size());
    end else if (int'(a) >= 3 && int'(a) < 3 + NR) begin
      r = m_res[int'(a) - 3];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [DW-1:0] d);
    if (a == 4'd0) begin
      if (d[0]) begin
        m_fill.delete();
        m_ovf   = 1'b0;
        m_irq   = 1'b0;
        m_phase = P_FILL;
        exp_pix.delete();
      end else if (d[1]) begin
        m_irq = 1'b0;
      end
    end else if (a == 4'd1) begin
      if (m_phase == P_FILL) begin
        m_fill.push_back(d);
        if (m_fill.size() == DEPTH) begin
          for (int i = 0; i < DEPTH; i++) exp_pix.push_back({(i == DEPTH - 1), m_fill[i]});
          m_phase = P_STREAM;
        end
      end else begin
        m_ovf = 1'b1;
      end
    end
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.address    = a;
    bus.writedata  = d;
    tick();
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a);
    exp_rd.push_back(model_read(a));
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.address    = a;
    tick();
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
  endtask

  task automatic res_write(input logic [3:0] idx, input logic [DW-1:0] d, input bit last,
                           input bit do_rd, input logic [3:0] rd_a);
    if (do_rd) exp_rd.push_back(model_read(rd_a));
    if (m_phase == P_WAIT) begin
      if (int'(idx) < NR) m_res[int'(idx)] = d;
      if (last) begin
        m_phase = P_DONE;
        m_irq   = IRQ_EN;
      end
    end
    bus.res_we   = 1'b1;
    bus.res_idx  = idx;
    bus.res_data = d;
    bus.res_last = last;
    if (do_rd) begin
      bus.chipselect = 1'b1;
      bus.read       = 1'b1;
      bus.address    = rd_a;
    end
    tick();
    bus.res_we     = 1'b0;
    bus.res_last   = 1'b0;
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
  endtask

  task automatic wait_stream();
    int cyc;
    cyc = 0;
    while ((exp_pix.size() != 0 || bus.out_valid) && cyc < 2000) begin
      tick();
      cyc++;
    end
    check("stream_timeout", (cyc >= 2000), 0);
    m_phase = P_WAIT;
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) bus_write(4'd1, DW'($urandom));
  endtask

  task automatic random_results();
    for (int k = 0; k < 15; k++)
      res_write(4'($urandom_range(0, 15)), DW'($urandom), (k == 14), (k % 3 == 0),
                4'($urandom_range(0, 15)));
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) bus_read(4'(a));
  endtask

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       bus.out_ready = rdy_manual;
      1:       bus.out_ready = (bus.out_ready === 1'b1) ? 1'b0 : 1'b1;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // monitor: read responses and pixel stream against the scoreboard queues
  bit rd_pend = 1'b0;
  always @(negedge clk) begin
    logic [DW:0] e;
    bit clr_now;
    if (rd_pend) begin
      if (exp_rd.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd_unexpected: got 0x%0h expected no response", bus.readdata);
      end else begin
        check("readdata", bus.readdata, exp_rd.pop_front());
      end
    end
    rd_pend = bus.chipselect && bus.read;
    clr_now = bus.chipselect && bus.write && (bus.address == 4'd0) && bus.writedata[0];
    if (bus.out_valid === 1'b1 && !clr_now) begin
      if (exp_pix.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL pix_unexpected: got 0x%0h expected no pixel", bus.out_data);
      end else begin
        e = exp_pix[0];
        check(bus.out_ready ? "pix_data" : "stall_data", bus.out_data, e[DW-1:0]);
        check(bus.out_ready ? "pix_last" : "stall_last", bus.out_last, e[DW]);
        if (bus.out_ready) void'(exp_pix.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    int cyc;
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.address    = '0;
    bus.writedata  = '0;
    bus.res_we     = 1'b0;
    bus.res_idx    = '0;
    bus.res_data   = '0;
    bus.res_last   = 1'b0;
    for (int i = 0; i < NR; i++) m_res[i] = '0;
    m_ovf   = 1'b0;
    m_irq   = 1'b0;
    m_phase = P_FILL;

    #1;
    check("rst_readdata", bus.readdata, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_irq", bus.irq, 0);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    bus_read(4'd0);
    bus_read(4'd2);

    // frame 1: counting pattern, ready held high
    for (int i = 0; i < DEPTH; i++) bus_write(4'd1, DW'(32'h0100 + i));
    check("valid_rise", bus.out_valid, 1);
    cyc = 0;
    while (exp_pix.size() != 0 && cyc < 200) begin
      tick();
      cyc++;
    end
    check("stream_cycles", cyc, DEPTH);
    wait_stream();
    bus_read(4'd2);
    res_write(4'd12, 16'hBEEF, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < NR; i++)
      res_write(4'(i), DW'(32'hA000 + i), (i == NR - 1), (i == 0) || (i == NR - 1),
                (i == 0) ? 4'd3 : 4'd0);
    check("irq_on_done", bus.irq, IRQ_EN);
    read_all();
    bus_write(4'd0, 16'h0002);
    check("irq_after_ack", bus.irq, 0);
    bus_read(4'd0);
    res_write(4'd0, 16'h5555, 1'b0, 1'b0, 4'd0);
    bus_read(4'd3);

    // frame 2: overflow while busy, toggled ready
    bus_write(4'd0, 16'h0001);
    bus_read(4'd0);
    bus_read(4'd2);
    bus_read(4'd5);
    res_write(4'd2, 16'h1234, 1'b1, 1'b0, 4'd0);
    rdy_mode = 1;
    fill_random();
    bus_write(4'd1, DW'($urandom));
    bus_read(4'd0);
    wait_stream();
    random_results();
    check("irq_frame2", bus.irq, IRQ_EN);
    read_all();
    bus_write(4'd0, 16'h0001);
    check("irq_cleared", bus.irq, 0);
    bus_read(4'd2);
    bus_read(4'd0);

    // frame 3: clear after 10 pixels
    rdy_mode   = 0;
    rdy_manual = 1'b1;
    fill_random();
    cyc = 0;
    while (exp_pix.size() > DEPTH - 10 && cyc < 200) begin
      tick();
      cyc++;
    end
    check("partial_stream", exp_pix.size(), DEPTH - 10);
    rdy_manual = 1'b0;
    bus_write(4'd0, 16'h0001);
    check("clr_out_valid", bus.out_valid, 0);
    check("clr_out_last", bus.out_last, 0);
    bus_read(4'd0);
    bus_read(4'd2);

    // frame 4: refill with random ready
    rdy_mode = 2;
    fill_random();
    wait_stream();
    random_results();
    read_all();
    bus_write(4'd0, 16'h0001);
    bus_read(4'd0);
    bus_read(4'd2);

    repeat (4) tick();
    check("rd_queue_empty", exp_rd.size(), 0);
    check("pix_queue_empty", exp_pix.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_result_buffer.md
# frame_result_buffer

- Avalon-MM slave between the HPS bus and the digit-recognition accelerator. Replaces the fixed 25-word, 10-result test buffer.
- The host pushes one frame of DEPTH pixel words through a data register. The block streams the frame to the accelerator over a valid/ready port.
- It then collects NUM_RESULTS class scores from the accelerator and exposes them as readable registers, with status, overflow and optional interrupt.

## Interface
- DATA_W, 16, pixel/result/bus word width (8..32)
- DEPTH, 25, pixels per frame (2..255)
- NUM_RESULTS, 10, result registers (1..12)
- clk  in  1  system clock; all logic rising-edge
- reset  in  1  asynchronous, active-low reset
- chipselect  in  1  Avalon slave select
- address  in  4  register word address
- read  in  1  Avalon read strobe
- write  in  1  Avalon write strobe
- writedata  in  DATA_W  host write data
- readdata  out  DATA_W  registered read data, reset 0
- out_data  out  DATA_W  pixel stream data, reset 0
- out_valid  out  1  pixel valid, reset 0
- out_last  out  1  marks pixel DEPTH-1, reset 0
- out_ready  in  1  accelerator accepts pixel
- res_we  in  1  result write strobe
- res_idx  in  4  result index
- res_data  in  DATA_W  result value
- res_last  in  1  final result, qualified by res_we
- irq  out  1  frame-done interrupt, reset 0

## Operation
- Address map:
  - 0: read STATUS; write CTRL.
  - 1: write DATA; reads return 0.
  - 2: read COUNT, zero-extended pixel count.
  - 3..3+NUM_RESULTS-1: read RESULT[address-3].
  - All other addresses: reads return 0, writes are ignored.
- STATUS bits:
  - [0] done
  - [1] busy (STREAM or WAIT)
  - [2] overflow, sticky
  - [3] irq_pending
  - others 0
- CTRL is written on address 0. Bit0=1 means clear: go to FILL, zero count, stream index, overflow, done and irq_pending. Result registers are retained. Bit0=0 has no effect.
- States are FILL, STREAM, WAIT, DONE. Reset state is FILL; all pointers and flags reset to 0; result registers reset to 0.
- FILL:
  - A DATA write stores writedata at buf[count] and increments count.
  - The write that makes count==DEPTH moves the block to STREAM.
- STREAM:
  - Presents buf[0..DEPTH-1] in order. out_last=1 on index DEPTH-1.
  - Transfer occurs when out_valid && out_ready.
  - out_data, out_valid and out_last hold stable while out_valid && !out_ready.
  - After the last transfer, go to WAIT.
- WAIT:
  - res_we with res_idx<NUM_RESULTS writes RESULT[res_idx]. res_idx>=NUM_RESULTS is ignored.
  - res_we && res_last moves the block to DONE and sets done.
  - res_we outside WAIT is ignored.
- DONE: results remain readable until CTRL clear.
- A DATA write outside FILL is dropped and sets overflow. The buffer and count are unchanged.
- Clear from any state takes effect next edge:
  - out_valid deasserts immediately.
  - A partially streamed frame is discarded.
  - A res_we in the same cycle as the clear is ignored.

## Timing
- Read latency 1. readdata updates on the edge after chipselect && read, and holds until the next read.
- A read of RESULT[i] in the same cycle as res_we to index i returns the old value.
- STATUS read in the cycle of a state change returns the pre-edge value.
- out_valid rises 1 cycle after the final FILL write.
- Steady throughput is 1 pixel/cycle with out_ready held high. The first pixel appears on the edge entering STREAM, so the buffer is read ahead one word.
- done rises on the edge after res_we && res_last.
- Asynchronous assertion of reset clears all outputs immediately, with any frame in flight lost. Deassertion is synchronised externally.

## Configuration
- FRAME_RESULT_BUFFER_IRQ_EN defined:
  - irq_pending is set on entry to DONE, and irq = irq_pending.
  - A CTRL write with bit1=1 acknowledges, clearing irq_pending only.
  - CTRL clear also clears it.
- Undefined:
  - irq is tied 0, STATUS[3] reads 0, and CTRL bit1 is ignored.
  - The host polls STATUS[0].

## Test plan
- Reset, 25 DATA writes of 0x0100+i, out_ready=1: out_data sequence 0x0100..0x0118 in 25 consecutive cycles, out_last only on 0x0118, COUNT reads 25.
- Stream with out_ready toggled 1/0 every cycle: no pixel duplicated or skipped; data held stable during stalls.
- In WAIT, res_we to indices 0..9 with 0xA000+idx and res_last on idx 9: STATUS=0x0001 (0x0009 with IRQ_EN); addresses 3..12 read 0xA000..0xA009; res_idx 12 write ignored.
- DATA write while busy: STATUS[2]=1, stream unaffected; CTRL clear returns COUNT 0, STATUS 0.
- CTRL clear mid-STREAM after 10 pixels: out_valid low next cycle; refill of 25 new pixels streams from index 0.
- With IRQ_EN: irq rises on DONE entry; CTRL write 0x2 drops irq while done stays 1. Without IRQ_EN: irq remains 0 throughout.
